block_emitter: RTL and testbench



---
 rtl/block_emitter_pkg.sv | 27 ++
 rtl/block_token_rom.sv | 52 +++++
 rtl/block_emitter.sv | 134 +++++++++++++
 tb/tb_block_emitter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_emitter_pkg.sv
// rtl/block_emitter_pkg.sv - opcodes, FSM states and ASCII constants for the block emitter
package block_emitter_pkg;

  localparam logic [1:0] OP_WORD  = 2'd0;
  localparam logic [1:0] OP_BEGIN = 2'd1;
  localparam logic [1:0] OP_END   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_SEP  = 2'd2
  } state_t;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_B        = 8'h62;
  localparam logic [7:0] CH_E        = 8'h65;
  localparam logic [7:0] CH_G        = 8'h67;
  localparam logic [7:0] CH_I        = 8'h69;
  localparam logic [7:0] CH_N        = 8'h6e;
  localparam logic [7:0] CH_D        = 8'h64;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  function automatic logic [7:0] apply_case(input logic [7:0] ch, input logic upper);
    return upper ? (ch - CASE_OFFSET) : ch;
  endfunction

endpackage

// File: rtl/block_token_rom.sv
// rtl/block_token_rom.sv - byte lookup for BEGIN/END/WORD tokens with last-index flag
module block_token_rom
  import block_emitter_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int IDX_W = 4
) (
  input  logic [1:0]       op,
  input  logic             upper,
  input  logic [IDX_W-1:0] index,
  input  logic [7:0]       fill,
  input  logic [LEN_W-1:0] len,
  output logic [7:0]       tok_byte,
  output logic             last
);

  logic [IDX_W:0] word_n;
  logic [IDX_W:0] pos;

  always_comb begin
    // A zero-length WORD still emits one fill byte.
    word_n   = (len == '0) ? (IDX_W+1)'(1) : (IDX_W+1)'(len);
    pos      = {1'b0, index} + (IDX_W+1)'(1);
    tok_byte = fill;
    last     = 1'b0;
    case (op)
      OP_BEGIN: begin
        case (index)
          IDX_W'(0): tok_byte = apply_case(CH_B, upper);
          IDX_W'(1): tok_byte = apply_case(CH_E, upper);
          IDX_W'(2): tok_byte = apply_case(CH_G, upper);
          IDX_W'(3): tok_byte = apply_case(CH_I, upper);
          default:   tok_byte = apply_case(CH_N, upper);
        endcase
        last = (index == IDX_W'(4));
      end
      OP_END: begin
        case (index)
          IDX_W'(0): tok_byte = apply_case(CH_E, upper);
          IDX_W'(1): tok_byte = apply_case(CH_N, upper);
          default:   tok_byte = apply_case(CH_D, upper);
        endcase
        last = (index == IDX_W'(2));
      end
      default: begin
        tok_byte = fill;
        last     = (pos >= word_n);
      end
    endcase
  end

endmodule

// File: rtl/block_emitter.sv
// rtl/block_emitter.sv - token-to-byte serializer with nesting-depth tracking
module block_emitter
  import block_emitter_pkg::*;
#(
  parameter int DEPTH_W = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic               cmd_upper,
  input  logic [7:0]         cmd_char,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               underflow,
  output logic               overflow
);

  // BEGIN needs indices 0..4, so the index counter is never narrower than 3 bits.
  localparam int IDX_W = (LEN_W < 3) ? 3 : LEN_W;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t           state;
  logic [1:0]       op_q;
  logic             upper_q;
  logic [7:0]       char_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] idx;
  logic             last_q;

  logic             accept;
  logic [1:0]       rom_op;
  logic             rom_upper;
  logic [7:0]       rom_fill;
  logic [LEN_W-1:0] rom_len;
  logic [IDX_W-1:0] rom_index;
  logic [7:0]       rom_byte;
  logic             rom_last;

  assign accept   = cmd_valid && cmd_ready;
  assign balanced = (depth == '0) && !underflow;

  // On accept the ROM looks up byte 0 of the incoming command; otherwise the next byte of the latched one.
  assign rom_op    = accept ? cmd_op    : op_q;
  assign rom_upper = accept ? cmd_upper : upper_q;
  assign rom_fill  = accept ? cmd_char  : char_q;
  assign rom_len   = accept ? cmd_len   : len_q;
  assign rom_index = accept ? '0 : (idx + IDX_W'(1));

  block_token_rom #(
    .LEN_W (LEN_W),
    .IDX_W (IDX_W)
  ) u_rom (
    .op       (rom_op),
    .upper    (rom_upper),
    .index    (rom_index),
    .fill     (rom_fill),
    .len      (rom_len),
    .tok_byte (rom_byte),
    .last     (rom_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      out       <= 8'h00;
      out_valid <= 1'b0;
      depth     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      op_q      <= OP_WORD;
      upper_q   <= 1'b0;
      char_q    <= 8'h00;
      len_q     <= '0;
      idx       <= '0;
      last_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        upper_q <= cmd_upper;
        char_q  <= cmd_char;
        len_q   <= cmd_len;
        case (cmd_op)
          OP_BEGIN: begin
            if (depth == DEPTH_MAX) overflow <= 1'b1;
            else                    depth    <= depth + DEPTH_W'(1);
          end
          OP_END: begin
            if (depth == '0) underflow <= 1'b1;
            else             depth     <= depth - DEPTH_W'(1);
          end
          default: ;
        endcase
      end

      case (state)
        S_EMIT: begin
          if (last_q) begin
            state     <= S_SEP;
            out       <= CH_SPACE;
            out_valid <= 1'b1;
            cmd_ready <= 1'b1;
          end else begin
            idx    <= rom_index;
            out    <= rom_byte;
            last_q <= rom_last;
          end
        end
        default: begin
          if (accept) begin
            state     <= S_EMIT;
            idx       <= '0;
            out       <= rom_byte;
            last_q    <= rom_last;
            out_valid <= 1'b1;
            cmd_ready <= 1'b0;
          end else begin
            state     <= S_IDLE;
            out       <= 8'h00;
            out_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_emitter.sv
// tb/tb_block_emitter.sv - directed and random checks of block_emitter against a string-level model
module tb_block_emitter;
  import block_emitter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_valid_s = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic       cmd_upper = 1'b0;
  logic [7:0] cmd_char = 8'h00;
  logic [3:0] cmd_len = 4'd0;

  logic       cmd_ready, out_valid, balanced, underflow, overflow;
  logic [7:0] out;
  logic [7:0] depth;
  logic       cmd_ready_s, out_valid_s, balanced_s, underflow_s, overflow_s;
  logic [7:0] out_s;
  logic [1:0] depth_s;

  block_emitter #(.DEPTH_W(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_upper(cmd_upper), .cmd_char(cmd_char), .cmd_len(cmd_len),
    .out(out), .out_valid(out_valid), .depth(depth), .balanced(balanced),
    .underflow(underflow), .overflow(overflow)
  );

  block_emitter #(.DEPTH_W(2), .LEN_W(4)) dut_s (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s),
    .cmd_op(cmd_op), .cmd_upper(cmd_upper), .cmd_char(cmd_char), .cmd_len(cmd_len),
    .out(out_s), .out_valid(out_valid_s), .depth(depth_s), .balanced(balanced_s),
    .underflow(underflow_s), .overflow(overflow_s)
  );

  always #5 clk = ~clk;

  int  tests = 0;
  int  failed = 0;
  byte unsigned exp_q[$];
  int  m_depth = 0;
  bit  m_under = 1'b0;
  bit  m_over = 1'b0;
  int  last_wait = 0;
  int  emitted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    if (out_valid) begin
      emitted++;
      chk("stream_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("out_byte", out, exp_q.pop_front());
    end else begin
      chk("idle_out", out, 8'h00);
      chk("no_bubble", exp_q.size(), 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Model: token text as a string, depth as a plain integer with saturation rules.
  task automatic model_accept(input logic [1:0] op, input logic up, input logic [7:0] ch, input logic [3:0] len);
    string s;
    int n;
    s = "";
    if (op == 2'd1) begin
      s = up ? "BEGIN" : "begin";
      if (m_depth == 255) m_over = 1'b1; else m_depth++;
    end else if (op == 2'd2) begin
      s = up ? "END" : "end";
      if (m_depth == 0) m_under = 1'b1; else m_depth--;
    end
    if (op == 2'd1 || op == 2'd2) begin
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end else begin
      n = (len == 0) ? 1 : int'(len);
      for (int i = 0; i < n; i++) exp_q.push_back(ch);
    end
    exp_q.push_back(8'h20);
  endtask

  task automatic issue(input logic [1:0] op, input logic up, input logic [7:0] ch, input logic [3:0] len);
    int w;
    w = 0;
    cmd_op = op; cmd_upper = up; cmd_char = ch; cmd_len = len; cmd_valid = 1'b1;
    while (!cmd_ready && w < 40) begin
      cycle();
      w++;
    end
    last_wait = w;
    chk("ready_bound", cmd_ready, 1);
    model_accept(op, up, ch, len);
    cycle();
    cmd_valid = 1'b0;
    chk("depth", depth, m_depth);
    chk("underflow", underflow, m_under);
    chk("overflow", overflow, m_over);
    chk("balanced", balanced, (m_depth == 0) && !m_under);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (out_valid && g < 40) begin
      cycle();
      g++;
    end
    chk("drain_bound", out_valid, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_valid_s = 1'b0;
    #1;
    exp_q.delete();
    m_depth = 0; m_under = 1'b0; m_over = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_out", out, 8'h00);
    chk("rst_valid", out_valid, 0);
    chk("rst_depth", depth, 0);
    chk("rst_under", underflow, 0);
    chk("rst_over", overflow, 0);
    chk("rst_bal", balanced, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int e0, w;
    logic [1:0] rop;
    logic rup;
    logic [7:0] rch;
    logic [3:0] rlen;

    @(posedge clk);
    #1;
    apply_reset();

    // begin end, back to back
    e0 = emitted;
    issue(OP_BEGIN, 1'b0, 8'h00, 4'd0);
    chk("depth_after_begin", depth, 1);
    issue(OP_END, 1'b0, 8'h00, 4'd0);
    chk("end_wait_cycles", last_wait, 5);
    drain();
    chk("begin_end_bytes", emitted - e0, 10);
    chk("be_balanced", balanced, 1);

    // END at depth 0, sticky underflow
    apply_reset();
    issue(OP_END, 1'b1, 8'h00, 4'd0);
    drain();
    chk("uf_flag", underflow, 1);
    chk("uf_depth", depth, 0);
    chk("uf_bal", balanced, 0);
    issue(OP_BEGIN, 1'b0, 8'h00, 4'd0);
    issue(OP_END, 1'b0, 8'h00, 4'd0);
    drain();
    chk("uf_sticky_bal", balanced, 0);

    // WORD lengths 3 and 0
    apply_reset();
    e0 = emitted;
    issue(OP_WORD, 1'b0, 8'h78, 4'd3);
    issue(OP_WORD, 1'b0, 8'h78, 4'd0);
    drain();
    chk("word_bytes", emitted - e0, 6);
    chk("word_depth", depth, 0);

    // nesting
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      issue(OP_BEGIN, 1'b1, 8'h00, 4'd0);
      chk("nest_up", depth, i);
    end
    issue(OP_END, 1'b0, 8'h00, 4'd0);
    chk("nest_d2", depth, 2);
    issue(OP_END, 1'b0, 8'h00, 4'd0);
    chk("nest_d1", depth, 1);
    chk("nest_unbal", balanced, 0);
    issue(OP_END, 1'b0, 8'h00, 4'd0);
    chk("nest_d0", depth, 0);
    chk("nest_bal", balanced, 1);
    drain();

    // DEPTH_W = 2 saturation
    apply_reset();
    cmd_op = OP_BEGIN; cmd_upper = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w = 0;
      cmd_valid_s = 1'b1;
      while (!cmd_ready_s && w < 40) begin
        cycle();
        w++;
      end
      chk("s_ready_bound", cmd_ready_s, 1);
      cycle();
      cmd_valid_s = 1'b0;
      chk("s_depth", depth_s, (i > 3) ? 3 : i);
      chk("s_overflow", overflow_s, i > 3);
    end
    chk("s_bal", balanced_s, 0);
    w = 0;
    while (out_valid_s && w < 40) begin
      cycle();
      w++;
    end
    chk("s_drain", out_valid_s, 0);

    // reset in the third cycle of a BEGIN
    apply_reset();
    issue(OP_BEGIN, 1'b0, 8'h00, 4'd0);
    cycle();
    cycle();
    chk("mid_byte_g", out, 8'h67);
    reset = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_depth", depth, 0);
    chk("abort_ready", cmd_ready, 1);
    apply_reset();
    issue(OP_WORD, 1'b1, 8'h71, 4'd2);
    drain();

    // random commands with idle gaps
    apply_reset();
    for (int k = 0; k < 60; k++) begin
      rop  = 2'($urandom_range(0, 3));
      rup  = 1'($urandom_range(0, 1));
      rch  = 8'($urandom_range(33, 126));
      rlen = 4'($urandom_range(0, 15));
      issue(rop, rup, rch, rlen);
      if ($urandom_range(0, 3) == 0) begin
        drain();
        repeat ($urandom_range(1, 3)) cycle();
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
